// File: rtl/riscv_cpu_pkg.sv
// Shared types for the CPU data-memory path: access widths and load/store unit states.
package riscv_cpu_pkg;

  typedef enum logic [1:0] {
    LSU_WORD  = 2'b00,
    LSU_HALF  = 2'b01,
    LSU_BYTE  = 2'b10,
    LSU_DWORD = 2'b11
  } lsu_data_type_e;

  typedef enum logic {
    LSU_IDLE,
    LSU_WAIT_RVALID
  } lsu_state_e;

endpackage

// File: rtl/lsu_rdata_align.sv
// Moves the addressed lane of a bus read word down to bit 0 and sign/zero-extends it to full width.
module lsu_rdata_align
  import riscv_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFFS_W     = 2
) (
  input  logic [OFFS_W-1:0]     offs_i,
  input  lsu_data_type_e        type_i,
  input  logic                  sign_ext_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] lane;
  logic                  fill;
  int                    nbits;

  always_comb begin
    lane = rdata_i >> {offs_i, 3'b000};
    case (type_i)
      LSU_BYTE: begin nbits = 8;          fill = sign_ext_i & lane[7];            end
      LSU_HALF: begin nbits = 16;         fill = sign_ext_i & lane[15];           end
      LSU_WORD: begin nbits = 32;         fill = sign_ext_i & lane[31];           end
      default:  begin nbits = DATA_WIDTH; fill = sign_ext_i & lane[DATA_WIDTH-1]; end
    endcase
    for (int i = 0; i < DATA_WIDTH; i++) begin
      rdata_o[i] = (i < nbits) ? lane[i] : fill;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access unit: bridges MEM-stage requests onto a req/gnt/rvalid bus with one
// outstanding transaction, lane steering of store data and alignment/extension of load data.
module load_store_unit
  import riscv_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       mem_req_i,
  input  logic                       mem_we_i,
  input  logic [1:0]                 mem_data_type_i,
  input  logic                       mem_sign_ext_i,
  input  logic [ADDR_WIDTH-1:0]      mem_addr_i,
  input  logic [DATA_WIDTH-1:0]      mem_wdata_i,
  output logic                       mem_gnt_o,
  output logic                       mem_rvalid_o,
  output logic [DATA_WIDTH-1:0]      mem_rdata_o,
  output logic                       mem_misaligned_o,
  output logic                       mem_err_o,
  output logic                       mem_busy_o,
  output logic                       data_req_o,
  input  logic                       data_gnt_i,
  input  logic                       data_rvalid_i,
  input  logic                       data_err_i,
  output logic [ADDR_WIDTH-1:0]      data_addr_o,
  output logic                       data_we_o,
  output logic [DATA_WIDTH/8-1:0]    data_be_o,
  output logic [DATA_WIDTH-1:0]      data_wdata_o,
  input  logic [DATA_WIDTH-1:0]      data_rdata_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int OFFS_W   = $clog2(BE_WIDTH);

  lsu_state_e            state_q, state_d;
  lsu_data_type_e        type_q, type_d;
  logic                  sign_ext_q, sign_ext_d;
  logic [OFFS_W-1:0]     offs_q, offs_d;
  logic                  we_q, we_d;

  lsu_data_type_e        req_type;
  logic [OFFS_W-1:0]     req_offs;
  logic                  misaligned;
  logic                  retire;
  logic                  issue_ok;
  logic                  grant_bus;
  logic [BE_WIDTH-1:0]   be_base;
  logic [DATA_WIDTH-1:0] aligned_rdata;

  always_comb begin
    req_type = lsu_data_type_e'(mem_data_type_i);
    req_offs = mem_addr_i[OFFS_W-1:0];
    // A dword on a 32-bit bus is illegal and is reported the same way as a misaligned access.
    case (req_type)
      LSU_BYTE: begin misaligned = 1'b0;                  be_base = BE_WIDTH'(1);     end
      LSU_HALF: begin misaligned = req_offs[0];           be_base = BE_WIDTH'(2'b11); end
      LSU_WORD: begin misaligned = (req_offs[1:0] != 2'b00); be_base = BE_WIDTH'(4'hF); end
      default:  begin misaligned = (DATA_WIDTH == 32) || (req_offs != '0); be_base = '1; end
    endcase

    retire    = (state_q == LSU_WAIT_RVALID) && data_rvalid_i;
    issue_ok  = (state_q == LSU_IDLE) || retire;
    grant_bus = issue_ok && mem_req_i && !misaligned && data_gnt_i;

    state_d    = state_q;
    type_d     = type_q;
    sign_ext_d = sign_ext_q;
    offs_d     = offs_q;
    we_d       = we_q;
    if (retire) begin
      state_d = LSU_IDLE;
    end
    if (grant_bus) begin
      state_d    = LSU_WAIT_RVALID;
      type_d     = req_type;
      sign_ext_d = mem_sign_ext_i;
      offs_d     = req_offs;
      we_d       = mem_we_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= LSU_IDLE;
      type_q     <= LSU_WORD;
      sign_ext_q <= 1'b0;
      offs_q     <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      sign_ext_q <= sign_ext_d;
      offs_q     <= offs_d;
      we_q       <= we_d;
    end
  end

  lsu_rdata_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .OFFS_W     (OFFS_W)
  ) u_rdata_align (
    .offs_i     (offs_q),
    .type_i     (type_q),
    .sign_ext_i (sign_ext_q),
    .rdata_i    (data_rdata_i),
    .rdata_o    (aligned_rdata)
  );

  // Handshake outputs are held low combinationally for the whole time reset is asserted.
  assign data_req_o       = rst_ni && issue_ok && mem_req_i && !misaligned;
  assign mem_gnt_o        = rst_ni && issue_ok && mem_req_i && (misaligned || data_gnt_i);
  assign mem_misaligned_o = rst_ni && issue_ok && mem_req_i && misaligned;
  assign mem_rvalid_o     = rst_ni && retire;
  assign mem_err_o        = rst_ni && retire && data_err_i;
  assign mem_busy_o       = rst_ni && (state_q == LSU_WAIT_RVALID);

  assign data_addr_o  = {mem_addr_i[ADDR_WIDTH-1:OFFS_W], {OFFS_W{1'b0}}};
  assign data_we_o    = mem_we_i;
  assign data_be_o    = be_base << req_offs;
  assign data_wdata_o = mem_wdata_i << {req_offs, 3'b000};
  assign mem_rdata_o  = (mem_rvalid_o && !we_q && !data_err_i) ? aligned_rdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit on a 32-bit bus.
module tb_load_store_unit;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          mem_req_i, mem_we_i, mem_sign_ext_i;
  logic [1:0]    mem_data_type_i;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] mem_wdata_i;
  logic          mem_gnt_o, mem_rvalid_o, mem_misaligned_o, mem_err_o, mem_busy_o;
  logic [DW-1:0] mem_rdata_o;
  logic          data_req_o, data_gnt_i, data_rvalid_i, data_err_i, data_we_o;
  logic [AW-1:0] data_addr_o;
  logic [3:0]    data_be_o;
  logic [DW-1:0] data_wdata_o, data_rdata_i;

  always #5 clk_i = ~clk_i;

  load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_data_type_i(mem_data_type_i),
    .mem_sign_ext_i(mem_sign_ext_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_gnt_o(mem_gnt_o), .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o),
    .mem_misaligned_o(mem_misaligned_o), .mem_err_o(mem_err_o), .mem_busy_o(mem_busy_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_err_i(data_err_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
  );

  typedef struct {
    bit          req, gnt, mis, rvalid, busy, we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cyc_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
  } cpl_t;

  cyc_t cyc_q[$];
  cpl_t cpl_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference-model state: what the bench believes is outstanding and what is being requested.
  bit          pending, active;
  int          rv_cnt, gnt_wait;
  logic [1:0]  a_type;
  bit          a_we, a_sign;
  logic [31:0] a_addr, a_wdata;
  logic [1:0]  x_type;
  bit          x_we, x_sign;
  logic [1:0]  x_offs;

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int type_bytes(logic [1:0] t);
    case (t)
      2'b00:   return 4;
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 8;
    endcase
  endfunction

  function automatic bit model_misaligned(logic [1:0] t, logic [31:0] addr);
    int n = type_bytes(t);
    return (n > 4) || ((addr % n) != 0);
  endfunction

  function automatic logic [3:0] model_be(logic [1:0] t, logic [31:0] addr);
    logic [3:0] be = '0;
    int o = addr % 4;
    for (int i = 0; i < type_bytes(t); i++) be[o + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] rdata, logic [1:0] t, bit sign,
                                             logic [1:0] offs);
    int          n    = type_bytes(t);
    logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
    logic [31:0] v    = (rdata >> (8 * offs)) & mask[31:0];
    if (sign && v[8 * n - 1]) v = v | ~mask[31:0];
    return v;
  endfunction

  // Monitor: compares every cycle against the expected record and every completion in order.
  initial begin
    cyc_t c;
    cpl_t p;
    forever begin
      @(negedge clk_i);
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        check_output("data_req", 32'(data_req_o), 32'(c.req));
        check_output("mem_gnt", 32'(mem_gnt_o), 32'(c.gnt));
        check_output("mem_misaligned", 32'(mem_misaligned_o), 32'(c.mis));
        check_output("mem_rvalid", 32'(mem_rvalid_o), 32'(c.rvalid));
        check_output("mem_busy", 32'(mem_busy_o), 32'(c.busy));
        if (c.req) begin
          check_output("data_addr", data_addr_o, c.addr);
          check_output("data_be", 32'(data_be_o), 32'(c.be));
          check_output("data_wdata", data_wdata_o, c.wdata);
          check_output("data_we", 32'(data_we_o), 32'(c.we));
        end
      end
      if (mem_rvalid_o) begin
        if (cpl_q.size() == 0) begin
          check_output("unexpected_completion", 32'(mem_rvalid_o), 32'd0);
        end else begin
          p = cpl_q.pop_front();
          check_output("mem_rdata", mem_rdata_o, p.rdata);
          check_output("mem_err", 32'(mem_err_o), 32'(p.err));
        end
      end
    end
  end

  task automatic new_request();
    int r = $urandom_range(0, 9);
    int n;
    a_type  = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
    a_addr  = $urandom;
    n       = type_bytes(a_type);
    if ($urandom_range(0, 2) != 0 && n <= 4) a_addr = a_addr - (a_addr % n);
    a_we    = $urandom_range(0, 1);
    a_sign  = $urandom_range(0, 1);
    a_wdata = $urandom;
    gnt_wait = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
    active  = 1;
  endtask

  task automatic apply_stimulus(bit rst_val, bit allow_new);
    cyc_t c;
    cpl_t p;
    bit   rv, mis, issue;
    c = '{default: 0};
    @(posedge clk_i);
    #1;
    rst_ni       = rst_val;
    data_rdata_i = $urandom;
    data_err_i   = ($urandom_range(0, 5) == 0);
    if (!rst_val) begin
      pending       = 0;
      active        = 0;
      mem_req_i     = 0;
      data_rvalid_i = $urandom_range(0, 1);
      data_gnt_i    = $urandom_range(0, 1);
      cyc_q.push_back(c);
      return;
    end
    rv = 0;
    if (pending) begin
      if (rv_cnt == 0) rv = 1;
      else rv_cnt--;
      data_rvalid_i = rv;
    end else begin
      data_rvalid_i = ($urandom_range(0, 7) == 0);
    end
    if (rv) begin
      p.err   = data_err_i;
      p.rdata = (x_we || data_err_i) ? 32'd0 : model_load(data_rdata_i, x_type, x_sign, x_offs);
      cpl_q.push_back(p);
    end
    if (!active && allow_new && $urandom_range(0, 3) != 0) new_request();
    mem_req_i       = active;
    mem_data_type_i = a_type;
    mem_addr_i      = a_addr;
    mem_we_i        = a_we;
    mem_sign_ext_i  = a_sign;
    mem_wdata_i     = a_wdata;
    issue    = !pending || rv;
    mis      = model_misaligned(a_type, a_addr);
    c.rvalid = rv;
    c.busy   = pending;
    if (rv) pending = 0;
    if (active && issue && !mis) data_gnt_i = (gnt_wait == 0);
    else data_gnt_i = $urandom_range(0, 1);
    if (active && issue) begin
      if (mis) begin
        c.gnt  = 1;
        c.mis  = 1;
        active = 0;
      end else begin
        c.req   = 1;
        c.we    = a_we;
        c.addr  = a_addr & ~32'h3;
        c.be    = model_be(a_type, a_addr);
        c.wdata = a_wdata << (8 * (a_addr % 4));
        if (gnt_wait == 0) begin
          c.gnt   = 1;
          active  = 0;
          pending = 1;
          rv_cnt  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
          x_type  = a_type;
          x_we    = a_we;
          x_sign  = a_sign;
          x_offs  = a_addr[1:0];
        end else begin
          gnt_wait--;
        end
      end
    end
    cyc_q.push_back(c);
  endtask

  initial begin
    rst_ni = 0; mem_req_i = 0; mem_we_i = 0; mem_data_type_i = 0; mem_sign_ext_i = 0;
    mem_addr_i = 0; mem_wdata_i = 0; data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0;
    data_rdata_i = 0;
    pending = 0; active = 0; rv_cnt = 0; gnt_wait = 0;
    a_type = 0; a_we = 0; a_sign = 0; a_addr = 0; a_wdata = 0;
    x_type = 0; x_we = 0; x_sign = 0; x_offs = 0;
    repeat (3) apply_stimulus(0, 0);
    for (int i = 0; i < 1500; i++) begin
      if ((i % 500) == 499) begin
        apply_stimulus(0, 0);
        apply_stimulus(0, 0);
      end else begin
        apply_stimulus(1, 1);
      end
    end
    for (int k = 0; k < 60 && (pending || active); k++) apply_stimulus(1, 0);
    if (pending || active) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout actual=busy expected=idle");
    end
    apply_stimulus(1, 0);
    @(negedge clk_i);
    #1;
    check_output("completions_left", 32'(cpl_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
